// File: rtl/fifo_sum.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sum
// Purpose  : UART column-sum engine. Bytes received over 8N1 UART fill a
//            matrix of COL_NUM columns row by row. From the third row on,
//            every byte is added to the bytes of the same column in the two
//            previous rows. Each sum is sent back over UART.
// Ports    : sys_clk   - system clock, rising edge
//            sys_rst_n - synchronous active-low reset
//            rx        - UART serial input (idle high, asynchronous)
//            tx        - UART serial output (idle high)
// Options  : FIFO_SUM_SAT_EN - when defined, sums above 255 are sent as 0xFF;
//            otherwise the low 8 bits of the sum are sent.
// Revision : 1.0 - initial release
// ============================================================================

// Synchronous FIFO with a registered read port. DEPTH must be a power of two
// so the pointers wrap naturally.
module fifo_sum_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             rd_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      count_q;
    logic [WIDTH-1:0] dout_q;
    logic             w_wr_ok;
    logic             w_rd_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign w_wr_ok = wr_i & ~full_o;
    assign w_rd_ok = rd_i & ~empty_o;
    assign dout_o  = dout_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
        end else begin
            if (w_wr_ok) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (w_rd_ok) begin
                rptr_q <= rptr_q + 1'b1;
                dout_q <= mem_q[rptr_q];
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wr_ok) begin
            mem_q[wptr_q] <= din_i;
        end
    end
endmodule

module fifo_sum #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 9600,
    parameter int COL_NUM  = 5
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic rx,
    output logic tx
);
    localparam int BAUD_CNT = CLK_FREQ / UART_BPS;
    localparam int CW       = $clog2(BAUD_CNT) + 1;
    localparam int COLW     = $clog2(COL_NUM);

    localparam logic [CW-1:0]   C_BAUD_LAST = CW'(BAUD_CNT - 1);
    localparam logic [CW-1:0]   C_HALF_LAST = CW'(BAUD_CNT / 2 - 1);
    localparam logic [CW-1:0]   C_FLAG_AT   = CW'(BAUD_CNT / 2);
    localparam logic [COLW-1:0] C_COL_LAST  = COLW'(COL_NUM - 1);

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_START = 2'd1,
        R_DATA  = 2'd2,
        R_STOP  = 2'd3
    } rx_state_e;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_LOAD = 2'd1,
        T_SEND = 2'd2
    } tx_state_e;

    // ---------------- receiver ----------------
    logic            rx_s1_q, rx_s2_q, rx_s3_q;
    rx_state_e       rx_state_q, rx_state_d;
    logic [CW-1:0]   rcnt_q, rcnt_d;
    logic [2:0]      rbit_q, rbit_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_flag_q, rx_flag_d;
    logic            w_fall;

    assign w_fall = rx_s3_q & ~rx_s2_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rcnt_d     = rcnt_q;
        rbit_d     = rbit_q;
        rx_data_d  = rx_data_q;
        rx_flag_d  = 1'b0;
        case (rx_state_q)
            R_IDLE: begin
                if (w_fall) begin
                    rx_state_d = R_START;
                    rcnt_d     = '0;
                end
            end
            R_START: begin
                // Walk to the middle of the start bit; all later samples
                // then land mid-bit after a full bit period each.
                if (rcnt_q == C_HALF_LAST) begin
                    rx_state_d = R_DATA;
                    rcnt_d     = '0;
                    rbit_d     = '0;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            R_DATA: begin
                if (rcnt_q == C_BAUD_LAST) begin
                    rcnt_d    = '0;
                    rx_data_d = {rx_s2_q, rx_data_q[7:1]};
                    if (rbit_q == 3'd7) begin
                        rx_state_d = R_STOP;
                    end else begin
                        rbit_d = rbit_q + 3'd1;
                    end
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            default: begin
                // Stop-bit level is not checked: the byte is always accepted.
                rcnt_d = rcnt_q + 1'b1;
                if (rcnt_q == C_FLAG_AT) begin
                    rx_flag_d = 1'b1;
                end
                if (rcnt_q == C_BAUD_LAST) begin
                    rx_state_d = R_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_s3_q    <= 1'b1;
            rx_state_q <= R_IDLE;
            rcnt_q     <= '0;
            rbit_q     <= '0;
            rx_data_q  <= '0;
            rx_flag_q  <= 1'b0;
        end else begin
            rx_s1_q    <= rx;
            rx_s2_q    <= rx_s1_q;
            rx_s3_q    <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rcnt_q     <= rcnt_d;
            rbit_q     <= rbit_d;
            rx_data_q  <= rx_data_d;
            rx_flag_q  <= rx_flag_d;
        end
    end

    // ---------------- row tracking and row-delay FIFOs ----------------
    logic [COLW-1:0] col_cnt_q;
    logic [1:0]      row_cnt_q;
    logic            pend_q;
    logic [7:0]      hold_q;
    logic [7:0]      sum_q;
    logic            sum_vld_q;
    logic [7:0]      w_sum_byte;
    logic            w_row0, w_row1, w_rown;
    logic            f1_wr, f1_rd, f1_empty, f1_full;
    logic            f2_wr, f2_rd, f2_empty, f2_full;
    logic [7:0]      f1_din, f1_dout, f2_din, f2_dout;
    logic            o_wr, o_rd, o_empty, o_full;
    logic [7:0]      o_dout;

    assign w_row0 = rx_flag_q && (row_cnt_q == 2'd0);
    assign w_row1 = rx_flag_q && (row_cnt_q == 2'd1);
    assign w_rown = rx_flag_q && (row_cnt_q == 2'd2);

    // In steady state FIFO1 holds row r-2 and FIFO2 holds row r-1. One cycle
    // after the pops, the older row's slot is refilled with row r-1 and the
    // newer one with row r, shifting the window down by a row.
    assign f1_wr  = (w_row0 | pend_q) & ~f1_full;
    assign f1_din = pend_q ? f2_dout : rx_data_q;
    assign f2_wr  = (w_row1 | pend_q) & ~f2_full;
    assign f2_din = pend_q ? hold_q : rx_data_q;
    assign f1_rd  = w_rown & ~f1_empty;
    assign f2_rd  = w_rown & ~f2_empty;

`ifdef FIFO_SUM_SAT_EN
    logic [9:0] w_sum;
    assign w_sum      = {2'b00, f1_dout} + {2'b00, f2_dout} + {2'b00, hold_q};
    assign w_sum_byte = (w_sum > 10'd255) ? 8'hFF : w_sum[7:0];
`else
    // Wrap-around keeps only the low byte, so the carry bits are never formed.
    assign w_sum_byte = f1_dout + f2_dout + hold_q;
`endif

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            col_cnt_q <= '0;
            row_cnt_q <= '0;
            pend_q    <= 1'b0;
            hold_q    <= '0;
            sum_q     <= '0;
            sum_vld_q <= 1'b0;
        end else begin
            if (rx_flag_q) begin
                if (col_cnt_q == C_COL_LAST) begin
                    col_cnt_q <= '0;
                    if (row_cnt_q != 2'd2) begin
                        row_cnt_q <= row_cnt_q + 2'd1;
                    end
                end else begin
                    col_cnt_q <= col_cnt_q + 1'b1;
                end
            end
            pend_q <= w_rown;
            if (w_rown) begin
                hold_q <= rx_data_q;
            end
            sum_vld_q <= pend_q;
            if (pend_q) begin
                sum_q <= w_sum_byte;
            end
        end
    end

    fifo_sum_fifo #(.WIDTH(8), .DEPTH(64)) u_fifo1 (
        .clk_i(sys_clk), .rst_ni(sys_rst_n), .wr_i(f1_wr), .din_i(f1_din),
        .rd_i(f1_rd), .dout_o(f1_dout), .empty_o(f1_empty), .full_o(f1_full)
    );

    fifo_sum_fifo #(.WIDTH(8), .DEPTH(64)) u_fifo2 (
        .clk_i(sys_clk), .rst_ni(sys_rst_n), .wr_i(f2_wr), .din_i(f2_din),
        .rd_i(f2_rd), .dout_o(f2_dout), .empty_o(f2_empty), .full_o(f2_full)
    );

    assign o_wr = sum_vld_q & ~o_full;

    fifo_sum_fifo #(.WIDTH(8), .DEPTH(16)) u_ofifo (
        .clk_i(sys_clk), .rst_ni(sys_rst_n), .wr_i(o_wr), .din_i(sum_q),
        .rd_i(o_rd), .dout_o(o_dout), .empty_o(o_empty), .full_o(o_full)
    );

    // ---------------- transmitter ----------------
    tx_state_e     tx_state_q, tx_state_d;
    logic [CW-1:0] tcnt_q, tcnt_d;
    logic [3:0]    tbit_q, tbit_d;
    logic [9:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tcnt_d     = tcnt_q;
        tbit_d     = tbit_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        o_rd       = 1'b0;
        case (tx_state_q)
            T_IDLE: begin
                tx_d = 1'b1;
                if (!o_empty) begin
                    o_rd       = 1'b1;
                    tx_state_d = T_LOAD;
                end
            end
            T_LOAD: begin
                // FIFO read data is valid now; frame = {stop, data, start}.
                shift_d    = {1'b1, o_dout, 1'b0};
                tx_d       = 1'b0;
                tcnt_d     = '0;
                tbit_d     = '0;
                tx_state_d = T_SEND;
            end
            default: begin
                if (tcnt_q == C_BAUD_LAST) begin
                    tcnt_d = '0;
                    if (tbit_q == 4'd9) begin
                        tx_d       = 1'b1;
                        tx_state_d = T_IDLE;
                    end else begin
                        tbit_d  = tbit_q + 4'd1;
                        shift_d = {1'b1, shift_q[9:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            tx_state_q <= T_IDLE;
            tcnt_q     <= '0;
            tbit_q     <= '0;
            shift_q    <= '1;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tcnt_q     <= tcnt_d;
            tbit_q     <= tbit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

    assign tx = tx_q;
endmodule
`default_nettype wire

// File: tb/tb_fifo_sum.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_sum
// Purpose  : Self-checking bench for fifo_sum. Bytes are sent as UART frames,
//            a monitor decodes tx frames, and a matrix model predicts the
//            column sums of every 3-row window.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_sum;
    localparam int CLK_FREQ = 50_000;
    localparam int UART_BPS = 9600;
    localparam int COL      = 5;
    localparam int B        = CLK_FREQ / UART_BPS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;
    logic tx;

    always #5 clk = ~clk;

    fifo_sum #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .COL_NUM(COL)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .rx(rx), .tx(tx)
    );

    int         checks = 0;
    int         failures = 0;
    int         tx_low = 0;
    int         stop_err = 0;
    int         base = 0;
    logic [7:0] sent[$];
    int         exp_q[$];
    logic [7:0] got[$];

    // tx frame decoder: sample mid-bit on the falling clock edge.
    initial begin : mon
        logic [7:0] b;
        b = '0;
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                repeat (B / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (B) @(negedge clk);
                    b[i] = tx;
                end
                repeat (B) @(negedge clk);
                if (tx !== 1'b1) stop_err++;
                got.push_back(b);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (tx !== 1'b1) tx_low++;
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (B) tick();
    endtask

    task automatic send_byte(input logic [7:0] v);
        sent.push_back(v);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
        send_bit(1'b1);
    endtask

    task automatic do_reset();
        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("tx_in_reset", {31'd0, tx}, 32'd1);
        end
        rst_n = 1'b1;
        sent.delete();
        tx_low = 0;
        @(negedge clk);
    endtask

    // Column sum over the current row and the two rows above it.
    task automatic build_exp();
        int s;
        exp_q.delete();
        for (int i = 2 * COL; i < sent.size(); i++) begin
            s = int'(sent[i]) + int'(sent[i-COL]) + int'(sent[i-2*COL]);
`ifdef FIFO_SUM_SAT_EN
            exp_q.push_back((s > 255) ? 255 : s);
`else
            exp_q.push_back(s % 256);
`endif
        end
    endtask

    task automatic finish_test(input string tag);
        int cyc;
        int n;
        build_exp();
        cyc = 0;
        while ((got.size() - base) < exp_q.size() && cyc < 20000) begin
            tick();
            cyc++;
        end
        repeat (150) tick();
        n = got.size() - base;
        check({tag, "_count"}, n, exp_q.size());
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            check($sformatf("%s_sum%0d", tag, i), {24'd0, got[base+i]}, exp_q[i]);
        end
        base = got.size();
    endtask

    initial begin
        // Reset state
        do_reset();
        check("tx_idle_after_reset", {31'd0, tx}, 32'd1);

        // 4 rows of 0x01..0x14
        for (int i = 1; i <= 20; i++) send_byte(8'(i));
        finish_test("ramp20");

        // Rows 0-1 only: no output at all
        do_reset();
        for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(0, 255)));
        finish_test("two_rows");
        check("two_rows_tx_low", tx_low, 0);

        // All 0xFF: exercises wrap / saturation
        do_reset();
        for (int i = 0; i < 15; i++) send_byte(8'hFF);
        finish_test("all_ff");

        // Reset mid-matrix and mid-frame discards partial data
        do_reset();
        for (int i = 0; i < 7; i++) send_byte(8'($urandom_range(0, 255)));
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        do_reset();
        for (int i = 1; i <= 15; i++) send_byte(8'(i));
        finish_test("reset_mid");

        // Single-cycle glitch: accepted as a start, sampled as an all-ones byte
        do_reset();
        @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        sent.push_back(8'hFF);
        repeat (15 * B) tick();
        for (int i = 1; i <= 15; i++) send_byte(8'(i));
        finish_test("glitch");

        // 40 back-to-back random bytes -> 30 sums
        do_reset();
        for (int i = 0; i < 40; i++) send_byte(8'($urandom_range(0, 255)));
        finish_test("b2b40");

        check("stop_bits", stop_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
